// File: rtl/snake_head_ctrl.sv
// rtl/snake_head_ctrl.sv - snake head position, direction buffering and game-level FSM
//
// Advances the snake head one grid cell per `enable` tick, buffers player
// direction requests between ticks (dropping 180-degree reversals) and detects
// wall collisions.
//
// Optional feature macro: SNAKE_WRAP_EN
//   undefined (default): leaving the grid ends the game (RUN -> DEAD).
//   defined            : leaving the grid wraps to the opposite edge.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   enable     in   one-cycle move tick from the rate divider
//   start      in   begin a new game (IDLE/DEAD -> RUN)
//   dir_in     in   requested direction: 00 up, 01 right, 10 down, 11 left
//   dir_valid  in   dir_in is valid this cycle
//   head_x     out  current head column
//   head_y     out  current head row
//   dir        out  direction used by the most recent move
//   head_valid out  one-cycle pulse: the head moved this cycle
//   running    out  FSM is in RUN
//   dead       out  FSM is in DEAD

module snake_head_ctrl #(
    parameter int GRID_W  = 32,
    parameter int GRID_H  = 24,
    parameter int X_W     = 5,
    parameter int Y_W     = 5,
    parameter int START_X = 16,
    parameter int START_Y = 12
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic           start,
    input  logic [1:0]     dir_in,
    input  logic           dir_valid,
    output logic [X_W-1:0] head_x,
    output logic [Y_W-1:0] head_y,
    output logic [1:0]     dir,
    output logic           head_valid,
    output logic           running,
    output logic           dead
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    localparam logic [1:0] D_UP    = 2'b00;
    localparam logic [1:0] D_RIGHT = 2'b01;
    localparam logic [1:0] D_DOWN  = 2'b10;
    localparam logic [1:0] D_LEFT  = 2'b11;

    localparam logic signed [X_W:0] X_ONE = (X_W+1)'(1);
    localparam logic signed [Y_W:0] Y_ONE = (Y_W+1)'(1);
    localparam logic signed [X_W:0] X_MAX = (X_W+1)'(GRID_W - 1);
    localparam logic signed [Y_W:0] Y_MAX = (Y_W+1)'(GRID_H - 1);

    state_t          state;
    logic [1:0]      pending;

    logic [1:0]      ref_dir;
    logic            accept;
    logic signed [X_W:0] x0, nx;
    logic signed [Y_W:0] y0, ny;
    logic            x_oob, y_oob, oob;

    // On a tick the pending direction is what gets committed, so reversal
    // checks compare against it rather than the previous move's direction.
    assign ref_dir = enable ? pending : dir;
    assign accept  = dir_valid && (dir_in != (ref_dir ^ 2'b10));

    assign x0 = $signed({1'b0, head_x});
    assign y0 = $signed({1'b0, head_y});

    always_comb begin
        nx = x0;
        ny = y0;
        case (pending)
            D_UP:    ny = y0 - Y_ONE;
            D_RIGHT: nx = x0 + X_ONE;
            D_DOWN:  ny = y0 + Y_ONE;
            default: nx = x0 - X_ONE;
        endcase
    end

    // A step past 2^X_W-1 overflows to a negative value in the one-bit-wider
    // signed intermediate, so the sign bit also catches the right/bottom edge
    // when the grid fills the whole coordinate range.
    assign x_oob = nx[X_W] || (nx > X_MAX);
    assign y_oob = ny[Y_W] || (ny > Y_MAX);
    assign oob   = x_oob || y_oob;

    assign running = (state == S_RUN);
    assign dead    = (state == S_DEAD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            head_x     <= X_W'(START_X);
            head_y     <= Y_W'(START_Y);
            dir        <= D_RIGHT;
            pending    <= D_RIGHT;
            head_valid <= 1'b0;
        end else begin
            head_valid <= 1'b0;
            case (state)
                S_RUN: begin
                    if (enable) begin
                        dir <= pending;
                        if (!oob) begin
                            head_x     <= nx[X_W-1:0];
                            head_y     <= ny[Y_W-1:0];
                            head_valid <= 1'b1;
                        end else begin
`ifdef SNAKE_WRAP_EN
                            // Only the axis of motion can leave the grid.
                            if (x_oob)
                                head_x <= (pending == D_LEFT) ? X_W'(GRID_W - 1) : '0;
                            else
                                head_x <= nx[X_W-1:0];
                            if (y_oob)
                                head_y <= (pending == D_UP) ? Y_W'(GRID_H - 1) : '0;
                            else
                                head_y <= ny[Y_W-1:0];
                            head_valid <= 1'b1;
`else
                            state <= S_DEAD;
`endif
                        end
                    end
                    if (accept)
                        pending <= dir_in;
                end
                default: begin
                    if (start) begin
                        state   <= S_RUN;
                        head_x  <= X_W'(START_X);
                        head_y  <= Y_W'(START_Y);
                        dir     <= D_RIGHT;
                        pending <= D_RIGHT;
                    end
                end
            endcase
        end
    end

endmodule
